// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Row/column codes, FSM states and the key map live here.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    WAIT_RELEASE,
    RELEASE_DEBOUNCE
  } state_t;

  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  function automatic logic [3:0] row_onecold(
    input logic [1:0] r
  );
    return ~(4'b0001 << r);
  endfunction

  function automatic logic one_low(
    input logic [3:0] p
  );
    logic ok;
    case (p)
      4'b1110, 4'b1101,
      4'b1011, 4'b0111: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [1:0] col_of(
    input logic [3:0] p
  );
    logic [1:0] c;
    case (p)
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      4'b0111: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  // Row 3 carries '*' as E and '#' as F.
  function automatic logic [3:0] key_code(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] k;
    case ({row, col})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchroniser for the asynchronous column returns.
// Resets to the idle (all released) pattern.
module keypad_scanner_col_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= COL_IDLE;
      q    <= COL_IDLE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, debounce, ghost rejection and
// key encoding into a single-cycle key_valid strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_sense,
  output logic [3:0] row_drive,
  output logic [3:0] digit,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CNT);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [3:0]       cs;
  state_t           state;
  logic [1:0]       row;
  logic [DIV_W-1:0] div_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic [3:0]       pat;
  logic [1:0]       col;
  logic             cs_valid;

  keypad_scanner_col_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (col_sense),
    .q     (cs)
  );

  assign cs_valid = one_low(cs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      row       <= 2'd0;
      row_drive <= ROW_RESET;
      div_cnt   <= '0;
      db_cnt    <= '0;
      pat       <= COL_IDLE;
      col       <= 2'd0;
      digit     <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (cs_valid) begin
              pat    <= cs;
              col    <= col_of(cs);
              db_cnt <= '0;
              state  <= DEBOUNCE;
            end else begin
              row       <= row + 2'd1;
              row_drive <= row_onecold(row + 2'd1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end
        DEBOUNCE: begin
          if (cs == pat) begin
            if (db_cnt == DB_LAST) begin
              digit     <= key_code(row, col);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= WAIT_RELEASE;
            end else begin
              db_cnt <= db_cnt + DB_ONE;
            end
          end else begin
            // Bounce: resume scanning from the following row.
            state     <= SCAN;
            div_cnt   <= '0;
            row       <= row + 2'd1;
            row_drive <= row_onecold(row + 2'd1);
          end
        end
        WAIT_RELEASE: begin
          if (cs == COL_IDLE) begin
            db_cnt <= '0;
            state  <= RELEASE_DEBOUNCE;
          end
        end
        RELEASE_DEBOUNCE: begin
          if (cs != COL_IDLE) begin
            state <= WAIT_RELEASE;
          end else if (db_cnt == DB_LAST) begin
            key_held  <= 1'b0;
            state     <= SCAN;
            row       <= 2'd0;
            row_drive <= ROW_RESET;
            div_cnt   <= '0;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a physical keypad model
// and a key-map reference table.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col_sense;
  logic [3:0] row_drive;
  logic [3:0] digit;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;
  logic [3:0]  exp_q[$];
  logic [3:0]  kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  int errors = 0;
  int checks = 0;
  int onecold_bad = 0;

  keypad_scanner #(
    .SCAN_DIV     (16),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_sense (col_sense),
    .row_drive (row_drive),
    .digit     (digit),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Pressed switch shorts its column to its row when that row is low.
  always_comb begin
    col_sense = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !row_drive[r]) col_sense[c] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] target, output int ok);
    int n;
    n = 0;
    while (row_drive == target && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (row_drive != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (row_drive == target) ? 1 : 0;
  endtask

  task automatic hold_key(input int k, input int hold, input int gap);
    exp_q.push_back(kmap[k]);
    pressed = '0;
    pressed[k] = 1'b1;
    wait_clks(hold);
    pressed = '0;
    wait_clks(gap);
  endtask

  // Monitor: every strobe must match the oldest expected key.
  always @(negedge clk) begin : mon
    logic [3:0] e;
    if ($countones(~row_drive) != 1) onecold_bad++;
    if (reset && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_key_valid: got digit %0h, required no strobe", digit);
      end else begin
        e = exp_q.pop_front();
        check("digit", int'(digit), int'(e));
        check("held_at_valid", int'(key_held), 1);
      end
    end
  end

  initial begin
    int n;
    int ok;
    int trans;
    int low_cnt;
    logic [3:0] prev;

    reset = 1'b0;
    wait_clks(3);
    check("rst_row", int'(row_drive), 4'hE);
    check("rst_digit", int'(digit), 0);
    check("rst_valid", int'(key_valid), 0);
    check("rst_held", int'(key_held), 0);
    reset = 1'b1;
    wait_clks(5);

    // Key 5, then time the release debounce.
    exp_q.push_back(kmap[5]);
    pressed[5] = 1'b1;
    wait_clks(200);
    check("held_t1", int'(key_held), 1);
    pressed = '0;
    n = 0;
    while (key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 10 || n > 11) begin
      errors++;
      $display("FAIL release_clks: got %0d required 10..11", n);
    end
    wait_clks(20);

    // 5-clock bounce on row2/col0 across the row2 sample point.
    wait_row(4'b1011, ok);
    check("glitch_row2_seen", ok, 1);
    wait_clks(12);
    pressed[8] = 1'b1;
    wait_clks(5);
    pressed = '0;
    wait_row(4'b0111, ok);
    check("glitch_row3_next", ok, 1);
    check("glitch_digit", int'(digit), int'(kmap[5]));
    check("glitch_held", int'(key_held), 0);
    wait_clks(30);

    hold_key(12, 200, 40);
    hold_key(14, 200, 40);

    // Ghosting: two keys on row0 must never be accepted.
    pressed[0] = 1'b1;
    pressed[3] = 1'b1;
    prev = row_drive;
    trans = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_drive != prev) begin
        check("ghost_rotate", int'(row_drive), int'({prev[2:0], prev[3]}));
        trans++;
        prev = row_drive;
      end
    end
    check("ghost_cycling", (trans >= 8) ? 1 : 0, 1);
    check("ghost_held", int'(key_held), 0);
    pressed = '0;
    wait_clks(40);

    // Long hold of D: one strobe only, key_held steady.
    exp_q.push_back(kmap[15]);
    pressed[15] = 1'b1;
    n = 0;
    while (!key_held && n < 150) begin
      @(negedge clk);
      n++;
    end
    check("long_held_rise", int'(key_held), 1);
    low_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!key_held) low_cnt++;
    end
    check("long_held_steady", low_cnt, 0);
    pressed = '0;
    wait_clks(40);

    for (int i = 0; i < 10; i++)
      hold_key($urandom_range(0, 15), $urandom_range(150, 300),
               $urandom_range(30, 60));

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);

    // Reset three clocks into DEBOUNCE of key '2'.
    reset = 1'b0;
    pressed = '0;
    wait_clks(2);
    pressed[1] = 1'b1;
    reset = 1'b1;
    wait_clks(19);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_row", int'(row_drive), 4'hE);
      check("midrst_digit", int'(digit), 0);
      check("midrst_held", int'(key_held), 0);
      check("midrst_valid", int'(key_valid), 0);
    end
    pressed = '0;
    reset = 1'b1;
    wait_clks(15);
    check("restart_row0", int'(row_drive), 4'hE);
    wait_clks(1);
    check("restart_row1", int'(row_drive), 4'hD);
    wait_clks(40);
    check("no_pending", exp_q.size(), 0);
    check("onecold", onecold_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
